// File: rtl/icache_pkg.sv
// Shared defaults and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LINE_WORDS_DEF = 4;
  localparam int SETS_DEF       = 16;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_FILL = 2'd2,
    IC_RESP = 2'd3
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag and data storage for the icache: one refill write port and a
// combinational read port addressed by set index.
module icache_array
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int SETS       = SETS_DEF,
  localparam int OFF_W     = $clog2(LINE_WORDS * 4),
  localparam int IDX_W     = $clog2(SETS),
  localparam int WORD_W    = $clog2(LINE_WORDS),
  localparam int TAG_W     = ADDR_WIDTH - IDX_W - OFF_W
) (
  input  logic                  clk,
  input  logic                  we_data_i,
  input  logic                  we_tag_i,
  input  logic [IDX_W-1:0]      w_idx_i,
  input  logic [WORD_W-1:0]     w_word_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [TAG_W-1:0]      w_tag_i,
  input  logic [IDX_W-1:0]      r_idx_i,
  input  logic [WORD_W-1:0]     r_word_i,
  output logic [TAG_W-1:0]      r_tag_o,
  output logic [DATA_WIDTH-1:0] r_data_o
);

  logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0]      tag_q  [SETS];

  // NOTE: storage arrays carry no reset; line validity lives in the
  // top-level valid vector, so stale contents here are never observed.
  always_ff @(posedge clk) begin
    if (we_data_i) data_q[w_idx_i][w_word_i] <= w_data_i;
    if (we_tag_i)  tag_q[w_idx_i]            <= w_tag_i;
  end

  assign r_tag_o  = tag_q[r_idx_i];
  assign r_data_o = data_q[r_idx_i][r_word_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: single-cycle hits, blocking
// line refill over a req/gnt + beat-stream memory port, fence.i flush.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int SETS       = SETS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_instr_o,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  ic_state_e             state_q, state_d;
  logic [TAG_W-1:0]      req_tag_q, req_tag_d;
  logic [IDX_W-1:0]      req_idx_q, req_idx_d;
  logic [WORD_W-1:0]     req_word_q, req_word_d;
  logic [WORD_W-1:0]     cnt_q, cnt_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]      in_tag;
  logic [IDX_W-1:0]      in_idx;
  logic [WORD_W-1:0]     in_word;
  logic [IDX_W-1:0]      rd_idx;
  logic [WORD_W-1:0]     rd_word;
  logic [TAG_W-1:0]      arr_tag;
  logic [DATA_WIDTH-1:0] arr_data;
  logic                  hit;
  logic                  beat_we;
  logic                  last_beat;
  logic                  unused_addr_bits;

  assign in_tag  = req_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign in_idx  = req_addr_i[OFF_W +: IDX_W];
  assign in_word = req_addr_i[2 +: WORD_W];
  assign unused_addr_bits = ^req_addr_i[1:0];

  // Lookups use the live address in IDLE; during refill the read port
  // follows the latched request so the response word can be fetched.
  assign rd_idx  = (state_q == IC_IDLE) ? in_idx  : req_idx_q;
  assign rd_word = (state_q == IC_IDLE) ? in_word : req_word_q;

  assign hit       = valid_q[in_idx] && (arr_tag == in_tag);
  assign beat_we   = (state_q == IC_FILL) && mem_rvalid_i;
  assign last_beat = beat_we && (cnt_q == LAST_WORD);

  assign req_ready_o = (state_q == IC_IDLE) && !flush_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_instr_o = rsp_instr_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;

  icache_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS)
  ) u_array (
    .clk       (clk),
    .we_data_i (beat_we),
    .we_tag_i  (last_beat),
    .w_idx_i   (req_idx_q),
    .w_word_i  (cnt_q),
    .w_data_i  (mem_rdata_i),
    .w_tag_i   (req_tag_q),
    .r_idx_i   (rd_idx),
    .r_word_i  (rd_word),
    .r_tag_o   (arr_tag),
    .r_data_o  (arr_data)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d      = state_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    req_word_d   = req_word_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    rsp_valid_d  = 1'b0;
    rsp_instr_d  = rsp_instr_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;

    unique case (state_q)
      IC_IDLE: begin
        if (flush_i) begin
          valid_d = '0;
        end else if (req_valid_i) begin
          req_tag_d  = in_tag;
          req_idx_d  = in_idx;
          req_word_d = in_word;
          if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_instr_d = arr_data;
          end else begin
            state_d    = IC_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {in_tag, in_idx, OFF_W'(0)};
          end
        end
      end
      IC_REQ: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = IC_FILL;
        end
      end
      IC_FILL: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_rvalid_i) cnt_d = cnt_q + 1'b1;
        if (last_beat) begin
          valid_d[req_idx_q] = 1'b1;
          rsp_valid_d = 1'b1;
          // The final beat is not yet in the array when it is the requested word.
          rsp_instr_d = (req_word_q == cnt_q) ? mem_rdata_i : arr_data;
          state_d     = IC_RESP;
        end
      end
      IC_RESP: begin
        if (flush_pend_q || flush_i) valid_d = '0;
        flush_pend_d = 1'b0;
        state_d      = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IC_IDLE;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      req_word_q   <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_instr_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      req_word_q   <= req_word_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_instr_q  <= rsp_instr_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, hits, conflict,
// grant stall, flush in FILL and IDLE, reset during refill.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_instr_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_addr_i   (req_addr_i),
    .req_ready_o  (req_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_instr_o  (rsp_instr_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss on addr, optional grant stall, four beats base..base+3, optional
  // flush on a chosen beat; checks the whole refill handshake and response.
  task automatic refill(input logic [31:0] addr, input logic [31:0] base,
                        input int stall, input int flush_beat);
    logic [31:0] line_addr;
    logic [1:0]  word;
    line_addr = {addr[31:4], 4'h0};
    word      = addr[3:2];
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    step();
    req_valid_i = 1'b0;
    check("miss_mem_req", 32'(mem_req_o), 32'd1);
    check("miss_mem_addr", mem_addr_o, line_addr);
    check("miss_no_rsp", 32'(rsp_valid_o), 32'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_mem_req", 32'(mem_req_o), 32'd1);
      check("stall_mem_addr", mem_addr_o, line_addr);
      check("stall_ready", 32'(req_ready_o), 32'd0);
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    check("gnt_req_drop", 32'(mem_req_o), 32'd0);
    for (int b = 0; b < 4; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = base + 32'(b);
      flush_i      = (b == flush_beat);
      step();
      if (b < 3) check("fill_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    mem_rvalid_i = 1'b0;
    flush_i      = 1'b0;
    check("fill_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("fill_rsp_instr", rsp_instr_o, base + 32'(word));
    step();
    check("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("post_rsp_hold", rsp_instr_o, base + 32'(word));
    check("post_rsp_ready", 32'(req_ready_o), 32'd1);
  endtask

  task automatic hit(input logic [31:0] addr, input logic [31:0] exp);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    step();
    check("hit_valid", 32'(rsp_valid_o), 32'd1);
    check("hit_instr", rsp_instr_o, exp);
    check("hit_no_mem", 32'(mem_req_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = 32'h0;
    flush_i = 1'b0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0;
    step();
    step();
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_instr", rsp_instr_o, 32'h0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    rst = 1'b0;
    step();

    // Cold miss, word 1 requested.
    refill(32'h8000_0004, 32'hA0, 0, -1);

    // Back-to-back hits on the filled line.
    hit(32'h8000_0000, 32'hA0);
    hit(32'h8000_0008, 32'hA2);
    hit(32'h8000_000C, 32'hA3);
    req_valid_i = 1'b0;
    step();
    check("hits_done_valid", 32'(rsp_valid_o), 32'd0);
    check("hits_done_hold", rsp_instr_o, 32'hA3);

    // Conflict on set 0, then the evicted line misses again behind a 5-cycle grant stall.
    refill(32'h8000_0100, 32'hB0, 0, -1);
    refill(32'h8000_0000, 32'hC0, 5, -1);
    hit(32'h8000_0004, 32'hC1);
    req_valid_i = 1'b0;
    step();

    // Flush during FILL: response still arrives, line then misses again.
    refill(32'h8000_0014, 32'hD0, 0, 1);
    refill(32'h8000_0014, 32'hE0, 0, -1);
    // The pending flush also dropped set 0.
    refill(32'h8000_0008, 32'hF0, 0, -1);

    // Flush in IDLE with a request present: not accepted, valid bits cleared.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h8000_0014;
    flush_i     = 1'b1;
    #1;
    check("flush_idle_ready", 32'(req_ready_o), 32'd0);
    step();
    check("flush_idle_no_rsp", 32'(rsp_valid_o), 32'd0);
    check("flush_idle_no_mem", 32'(mem_req_o), 32'd0);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    step();
    refill(32'h8000_0014, 32'h10, 0, -1);

    // Reset after two of four beats.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h8000_0028;
    step();
    req_valid_i = 1'b0;
    check("rst_test_miss", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h20 + 32'(b);
      step();
    end
    mem_rvalid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mem_req", 32'(mem_req_o), 32'd0);
    check("async_rst_mem_addr", mem_addr_o, 32'h0);
    check("async_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("async_rst_rsp_instr", rsp_instr_o, 32'h0);
    step();
    rst = 1'b0;
    for (int b = 2; b < 4; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h20 + 32'(b);
      step();
      check("late_beat_no_rsp", 32'(rsp_valid_o), 32'd0);
      check("late_beat_no_mem", 32'(mem_req_o), 32'd0);
    end
    mem_rvalid_i = 1'b0;
    check("post_rst_ready", 32'(req_ready_o), 32'd1);
    refill(32'h8000_0028, 32'h30, 0, -1);
    // Lines filled before the reset are gone too.
    refill(32'h8000_0014, 32'h40, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
